// File: rtl/comparator_pkg.sv
// Shared types and helpers for the sequential chunked comparator.
package comparator_pkg;

  // Compare modes, encoded like RISC-V branch funct3.
  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LT  = 3'b100,
    CMP_GE  = 3'b101,
    CMP_LTU = 3'b110,
    CMP_GEU = 3'b111
  } cmp_mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } cmp_state_t;

  // Signed modes are folded into an unsigned compare by flipping the sign bits.
  function automatic logic is_signed(input cmp_mode_t m);
    return (m == CMP_LT) || (m == CMP_GE);
  endfunction

  // Maps the raw eq/lt flags onto the mode-selected result bit.
  // The two unused encodings (010/011) always yield 0.
  function automatic logic select_result(input cmp_mode_t m, input logic eq_v,
                                         input logic lt_v);
    case (m)
      CMP_EQ:           return eq_v;
      CMP_NE:           return !eq_v;
      CMP_LT, CMP_LTU:  return lt_v;
      CMP_GE, CMP_GEU:  return !lt_v;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/comparator_eq.sv
// Combinational equality test of two N-bit words.
module comparator_eq #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle handshaked comparator: scans CHUNK bits per cycle from the MSB
// end and stops at the first differing chunk.
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  cmp_mode_t    mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out,
  output logic         eq,
  output logic         lt
);

  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCH        = N / CHUNK_SAFE;
  localparam int IW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);
  localparam logic [N-1:0]  SIGN_BIT = N'(1) << (N - 1);

  if ((CHUNK < 1) || ((N % CHUNK_SAFE) != 0)) begin : g_bad_params
    $error("comparator_seq: CHUNK must be >= 1 and divide N");
  end

  cmp_state_t      state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [N-1:0]    a_r, b_r;
  cmp_mode_t       mode_r;
  logic            eq_n, lt_n, out_n;
  logic [CHUNK-1:0] ca, cb;
  logic            chunk_eq;
  logic            chunk_lt;
  logic            capture;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign capture   = in_valid && in_ready;

  // Operand capture; sign bits flipped so signed modes reuse the unsigned compare.
  // NOTE: pure datapath registers carry no reset; they are only read after a
  // capture has written them, and leaving reset off keeps their flops cheap.
  always_ff @(posedge clk) begin
    if (capture) begin
      a_r    <= a ^ (is_signed(mode) ? SIGN_BIT : '0);
      b_r    <= b ^ (is_signed(mode) ? SIGN_BIT : '0);
      mode_r <= mode;
    end
  end

  // Selects the chunk addressed by the scan index.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCH; i++) begin
      if (idx == IW'(i)) begin
        ca = a_r[i*CHUNK_SAFE +: CHUNK_SAFE];
        cb = b_r[i*CHUNK_SAFE +: CHUNK_SAFE];
      end
    end
  end

  comparator_eq #(.N(CHUNK_SAFE)) u_chunk_eq (
    .a  (ca),
    .b  (cb),
    .eq (chunk_eq)
  );

  assign chunk_lt = (ca < cb);

  // Control and result state register.
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      out   <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      eq    <= eq_n;
      lt    <= lt_n;
      out   <= out_n;
    end
  end

  // Next-state logic: accept, scan one chunk per cycle, hold result until taken.
  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    eq_n    = eq;
    lt_n    = lt;
    out_n   = out;
    case (state)
      S_IDLE: begin
        if (capture) begin
          idx_n   = IDX_LAST;
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!chunk_eq) begin
          eq_n    = 1'b0;
          lt_n    = chunk_lt;
          out_n   = select_result(mode_r, 1'b0, chunk_lt);
          state_n = S_DONE;
        end else if (idx == '0) begin
          eq_n    = 1'b1;
          lt_n    = 1'b0;
          out_n   = select_result(mode_r, 1'b1, 1'b0);
          state_n = S_DONE;
        end else begin
          idx_n = idx - 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Directed self-checking bench for comparator_seq (N=32/CHUNK=8 and N=CHUNK=16).
module tb_comparator_seq;
  import comparator_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  cmp_mode_t   mode = CMP_EQ;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out, eq, lt;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [15:0] a16 = '0, b16 = '0;
  cmp_mode_t   mode16 = CMP_EQ;
  logic        out_valid16;
  logic        out16, eq16, lt16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  comparator_seq #(.N(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .eq        (eq),
    .lt        (lt)
  );

  comparator_seq #(.N(16), .CHUNK(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .mode      (mode16),
    .out_valid (out_valid16),
    .out_ready (1'b1),
    .out       (out16),
    .eq        (eq16),
    .lt        (lt16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge right after the accept edge.
  task automatic send(input string tag, input logic [31:0] av, input logic [31:0] bv,
                      input cmp_mode_t mv);
    a = av;
    b = bv;
    mode = mv;
    in_valid = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid and checks latency and result flags.
  task automatic collect(input string tag, input int exp_lat, input logic exp_out,
                         input logic exp_eq, input logic exp_lt);
    int cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (out_valid) break;
    end
    check({tag, ".lat"}, 32'(cnt), 32'(exp_lat));
    check({tag, ".out"}, 32'(out), 32'(exp_out));
    check({tag, ".eq"},  32'(eq),  32'(exp_eq));
    check({tag, ".lt"},  32'(lt),  32'(exp_lt));
  endtask

  // Consumes the result with out_ready=1 and checks the one-cycle bubble.
  task automatic drain(input string tag);
    @(negedge clk);
    check({tag, ".drop"}, 32'(out_valid), 32'd0);
    check({tag, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out",       32'(out),       32'd0);
    check("rst.eq",        32'(eq),        32'd0);
    check("rst.lt",        32'(lt),        32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.release", 32'(in_ready), 32'd1);
    @(negedge clk);

    send("eq_dead", 32'hDEADBEEF, 32'hDEADBEEF, CMP_EQ);
    collect("eq_dead", 4, 1'b1, 1'b1, 1'b0);
    drain("eq_dead");

    send("lt_sgn", 32'h80000000, 32'h00000001, CMP_LT);
    collect("lt_sgn", 1, 1'b1, 1'b0, 1'b1);
    drain("lt_sgn");

    send("ltu", 32'h80000000, 32'h00000001, CMP_LTU);
    collect("ltu", 1, 1'b0, 1'b0, 1'b0);
    drain("ltu");

    send("geu", 32'h80000000, 32'h00000001, CMP_GEU);
    collect("geu", 1, 1'b1, 1'b0, 1'b0);
    drain("geu");

    send("ltu_lsb", 32'h12345678, 32'h12345679, CMP_LTU);
    collect("ltu_lsb", 4, 1'b1, 1'b0, 1'b1);
    drain("ltu_lsb");

    send("ge_swap", 32'h12345679, 32'h12345678, CMP_GE);
    collect("ge_swap", 4, 1'b1, 1'b0, 1'b0);
    drain("ge_swap");

    send("ge_neg", 32'hFFFFFFFF, 32'h00000000, CMP_GE);
    collect("ge_neg", 1, 1'b0, 1'b0, 1'b1);
    drain("ge_neg");

    send("ne_diff", 32'h00AA0000, 32'h00BB0000, CMP_NE);
    collect("ne_diff", 2, 1'b1, 1'b0, 1'b1);
    drain("ne_diff");

    send("mode010", 32'd3, 32'd7, cmp_mode_t'(3'b010));
    collect("mode010", 4, 1'b0, 1'b0, 1'b1);
    drain("mode010");

    // Backpressure: result held, new operands refused while in S_DONE.
    out_ready = 1'b0;
    send("bp", 32'hCAFE0000, 32'hCAFF0000, CMP_LTU);
    collect("bp", 2, 1'b1, 1'b0, 1'b1);
    a = 32'h00000010;
    b = 32'h00000020;
    mode = CMP_LTU;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.valid_held", 32'(out_valid), 32'd1);
      check("bp.ready_low",  32'(in_ready),  32'd0);
      check("bp.out_held",   32'(out),       32'd1);
      check("bp.eq_held",    32'(eq),        32'd0);
      check("bp.lt_held",    32'(lt),        32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.handshake", 32'(out_valid), 32'd0);
    check("bp.bubble",    32'(in_ready),  32'd1);
    check("bp.out_kept",  32'(out),       32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.next_accepted", 32'(in_ready), 32'd0);
    collect("bp_next", 4, 1'b1, 1'b0, 1'b1);
    drain("bp_next");

    // Asynchronous reset in the middle of a scan.
    send("abort", 32'd0, 32'd0, CMP_EQ);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.in_ready",  32'(in_ready),  32'd0);
    check("abort.lt_clr",    32'(lt),        32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort.release", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort.no_stale", 32'(out_valid), 32'd0);
    end
    send("post_rst", 32'd5, 32'd5, CMP_NE);
    collect("post_rst", 4, 1'b0, 1'b1, 1'b0);
    drain("post_rst");

    // Single-chunk variant: N == CHUNK == 16.
    begin
      int cnt = 0;
      a16 = 16'hFFFF;
      b16 = 16'h0001;
      mode16 = CMP_LT;
      in_valid16 = 1'b1;
      check("n16.in_ready", 32'(in_ready16), 32'd1);
      @(negedge clk);
      in_valid16 = 1'b0;
      while (cnt < 20) begin
        @(negedge clk);
        cnt++;
        if (out_valid16) break;
      end
      check("n16.lat", 32'(cnt),   32'd1);
      check("n16.out", 32'(out16), 32'd1);
      check("n16.eq",  32'(eq16),  32'd0);
      check("n16.lt",  32'(lt16),  32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Multi-cycle, handshaked, parametrised magnitude/equality comparator for wide operands.
- Scans operands CHUNK bits per cycle, MSB chunk first, and exits early at the first differing chunk.
- Supports six compare modes (EQ/NE/LT/GE/LTU/GEU), encoded like RISC-V branch funct3, so it can back a multi-cycle branch unit.
- Sits between an operand producer (valid/ready) and a result consumer (valid/ready).

Parameters:
- N, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle. N % CHUNK == 0 and CHUNK >= 1 are required; violation is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  block can accept operands.
- a  in  N  operand A.
- b  in  N  operand B.
- mode  in  3  compare mode (cmp_mode_t).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out  out  1  mode-selected result.
- eq  out  1  a == b.
- lt  out  1  a < b, signed for signed modes, unsigned otherwise.

Behaviour:
- Reset (async, active-high), applied immediately: state=S_IDLE, out_valid=0, out=0, eq=0, lt=0, chunk index=0. in_ready=0 while rst is high.
- FSM states: S_IDLE, S_SCAN, S_DONE.
- in_ready is 1 only in S_IDLE with rst low. out_valid is 1 only in S_DONE.
- S_IDLE:
  - On in_valid & in_ready: register a, b, mode; set idx = N/CHUNK-1; go to S_SCAN.
  - Signed modes (LT, GE): invert bit N-1 of both registered operands at capture, then compare unsigned.
- S_SCAN, one chunk per cycle: ca = a_r[idx*CHUNK +: CHUNK], cb likewise.
  - If ca != cb: eq=0, lt=(ca<cb); go to S_DONE.
  - Else if idx == 0: eq=1, lt=0; go to S_DONE.
  - Else: idx <= idx-1.
- S_DONE:
  - out, eq, lt are stable and held while out_ready=0.
  - On out_ready: go to S_IDLE. out/eq/lt keep their last values; only out_valid drops.
- Result mapping:
  - EQ: out=eq. NE: out=~eq.
  - LT/LTU: out=lt. GE/GEU: out=~lt.
  - Modes 010/011: out=0; eq and lt are still computed unsigned.
- Latency, from the accept edge to out_valid: 1..N/CHUNK cycles. It is k when the first differing chunk is the k-th from the MSB, and N/CHUNK when the operands are equal.
- Throughput: S_DONE→S_IDLE costs one bubble, so there is at least one cycle between accepting operands and accepting the next set.
- Inputs are ignored outside S_IDLE. Registered operands are immune to input changes after accept.
- Reset mid-S_SCAN or mid-S_DONE aborts the transaction; no result is emitted.
- Index counter width is max(1, $clog2(N/CHUNK)).
- N == CHUNK is legal: single scan cycle.

Decomposition:
- Package comparator_pkg:
  - typedef enum logic [2:0] cmp_mode_t: CMP_EQ=000, CMP_NE=001, CMP_LT=100, CMP_GE=101, CMP_LTU=110, CMP_GEU=111.
  - typedef enum cmp_state_t {S_IDLE, S_SCAN, S_DONE}.
  - Function is_signed(cmp_mode_t).
- Sub-module: comparator_eq instantiated with N=CHUNK for the per-chunk equality test. The chunk less-than is inline.

Test Plan (N=32, CHUNK=8):
- a=b=0xDEADBEEF, mode=EQ, out_ready=1 → out_valid rises 4 cycles after accept; out=1, eq=1, lt=0.
- a=0x80000000, b=0x00000001:
  - mode=LT → out=1, lt=1, 1-cycle latency.
  - Repeat with mode=LTU → out=0; GEU → out=1.
- a=0x12345678, b=0x12345679, mode=LTU → 4-cycle latency, out=1. Swapped operands with mode=GE → out=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → out/eq/lt stable, in_ready=0. A new in_valid with different operands is not accepted. Raising out_ready gives a single handshake, and the next accept happens no earlier than the following cycle.
- Reset mid-S_SCAN (a=0, b=0, EQ, rst pulsed after 2 scan cycles, asynchronous to clk) → out_valid=0 and in_ready=0 immediately. After release: in_ready=1, and the next transaction (a=5, b=5, NE) gives out=0 with no stale result.
- mode=010, a=3, b=7 → out=0, eq=0, lt=1. Parameter variant N=CHUNK=16 with a=0xFFFF, b=0x0001, LT → out=1 after 1 cycle.
